// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// master = the side driving requests and data; slave = the FIFO itself.
interface fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [WIDTH-1:0]  data_in;
    logic              rd_en;
    logic [WIDTH-1:0]  data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              err_clr;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en, err_clr,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, err_clr,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO using all DEPTH entries, with occupancy and thresholds.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic   clk,
    input  logic   rst,
    fifo_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic [WIDTH-1:0]  data_q;
    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;

    // Extra wrap bit keeps full (count==DEPTH) distinct from empty (count==0).
    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign rd_acc = bus.rd_en & ~empty;
    assign wr_acc = bus.wr_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            data_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                data_q <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // On full with simultaneous read, both addresses coincide; the read sees the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
    end

    assign bus.data_out     = data_q;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AFULL_C);
    assign bus.almost_empty = (count <= AEMPTY_C);

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // err_clr wins over a same-cycle refusal.
    always_ff @(posedge clk) begin
        if (rst || bus.err_clr) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && !wr_acc) overflow_q  <= 1'b1;
            if (bus.rd_en && !rd_acc) underflow_q <= 1'b1;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed + randomized bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_ovf  = 1'b0;
    bit               m_udf  = 1'b0;
    int               n_wr, n_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":count"},  32'(bus.count),        32'(q.size()));
        check({tag, ":empty"},  32'(bus.empty),        32'(q.size() == 0));
        check({tag, ":full"},   32'(bus.full),         32'(q.size() == DEPTH));
        check({tag, ":afull"},  32'(bus.almost_full),  32'(q.size() >= AF));
        check({tag, ":aempty"}, 32'(bus.almost_empty), 32'(q.size() <= AE));
        check({tag, ":dout"},   32'(bus.data_out),     32'(m_dout));
        check({tag, ":ovf"},    32'(bus.overflow),     32'(m_ovf));
        check({tag, ":udf"},    32'(bus.underflow),    32'(m_udf));
    endtask

    // One clock: drive inputs, advance the model by the same edge, then check after it.
    task automatic cycle(input string tag, input bit rs, input bit w, input logic [WIDTH-1:0] d,
                         input bit r, input bit c);
        bit rd_ok, wr_ok;
        rst         = rs;
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
        bus.err_clr = c;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
`ifdef FIFO_ERR_FLAGS_EN
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (w && !wr_ok) m_ovf = 1'b1;
                if (r && !rd_ok) m_udf = 1'b1;
            end
`endif
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.err_clr = 1'b0; bus.data_in = '0;

        // Reset for two cycles
        cycle("rst", 1, 0, 8'h00, 0, 0);
        cycle("rst", 1, 1, 8'hFF, 1, 0);

        // Fill with 0x01..0x10, then drain in order
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 0, 1, 8'(i), 0, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle("drain", 0, 0, 8'h00, 1, 0);
            check("drain_order", 32'(bus.data_out), 32'(i));
        end

        // Full with simultaneous write+read
        for (int i = 1; i <= DEPTH; i++) cycle("fill2", 0, 1, 8'(i), 0, 0);
        cycle("full_wr_rd", 0, 1, 8'hAA, 1, 0);
        check("full_wr_rd_head", 32'(bus.data_out), 32'h01);
        check("full_wr_rd_count", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cycle("drain2", 0, 0, 8'h00, 1, 0);
        check("drain2_last", 32'(bus.data_out), 32'hAA);

        // Empty with simultaneous write+read: no bypass
        cycle("empty_wr_rd", 0, 1, 8'h55, 1, 0);
        check("empty_wr_rd_count", 32'(bus.count), 32'd1);
        check("empty_wr_rd_hold", 32'(bus.data_out), 32'hAA);
        cycle("read_55", 0, 0, 8'h00, 1, 0);
        check("read_55_val", 32'(bus.data_out), 32'h55);

        // Overflow / underflow and err_clr
        for (int i = 0; i < DEPTH; i++) cycle("fill3", 0, 1, 8'(8'hC0 + i), 0, 0);
        cycle("overflow", 0, 1, 8'hEE, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle("drain3", 0, 0, 8'h00, 1, 0);
        cycle("underflow", 0, 0, 8'h00, 1, 0);
        cycle("err_clr_prio", 0, 0, 8'h00, 1, 1);
        cycle("idle", 0, 0, 8'h00, 0, 0);
        cycle("err_clr", 0, 0, 8'h00, 0, 1);

        // Randomized interleaved traffic: 40 writes / 40 reads, bounded
        n_wr = 0; n_rd = 0;
        for (int k = 0; k < 2000 && (n_wr < 40 || n_rd < 40); k++) begin
            bit w, r;
            w = (n_wr < 40) && ($urandom_range(0, 99) < 60);
            r = (n_rd < n_wr) && ($urandom_range(0, 99) < 55);
            if (w && (q.size() < DEPTH || r)) n_wr++;
            if (r && q.size() > 0) n_rd++;
            cycle("rand", 0, w, 8'($urandom), r, ($urandom_range(0, 19) == 0));
        end
        check("rand_done_wr", 32'(n_wr), 32'd40);
        check("rand_done_rd", 32'(n_rd), 32'd40);

        // Reset mid-traffic with 9 words stored
        for (int i = 0; i < 9; i++) cycle("fill9", 0, 1, 8'(8'h90 + i), 0, 0);
        check("fill9_count", 32'(bus.count), 32'd9);
        cycle("mid_rst", 1, 1, 8'h77, 1, 0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        cycle("post_rst_wr", 0, 1, 8'h3C, 0, 0);
        cycle("post_rst_rd", 0, 0, 8'h00, 1, 0);
        check("post_rst_new", 32'(bus.data_out), 32'h3C);
        cycle("post_rst_empty", 0, 0, 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
